uart_io_bridge: RTL and testbench



---
 rtl/uart_io_bridge.sv | 187 ++++++++++++++++++
 tb/tb_uart_io_bridge.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_bridge.sv
// UART receiver and packet parser that rebuilds the switch word and button vector from
// 5-byte host packets (A5, SW_HI, SW_LO, BTN, CHK). Buttons are momentary with a hold time.
module uart_io_bridge #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int TIMEOUT_CYCLES  = 1_000_000,
    parameter int BTN_HOLD_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [15:0] sw_out,
    output logic [3:0]  btn_out,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam int HW = (BTN_HOLD_CYCLES > 0) ? $clog2(BTN_HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(BTN_HOLD_CYCLES);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HDR, P_SWH, P_SWL, P_BTN, P_CHK} p_state_t;

    logic [1:0]    sync_q, sync_d;
    logic          rx_prev_q, rx_prev_d;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    p_state_t      p_state_q, p_state_d;
    logic [7:0]    sw_hi_q, sw_hi_d;
    logic [7:0]    sw_lo_q, sw_lo_d;
    logic [7:0]    btn_byte_q, btn_byte_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   sw_q, sw_d;
    logic [3:0]    btn_q, btn_d;
    logic          frame_valid_q, frame_valid_d;
    logic          frame_err_q, frame_err_d;

    logic rx_s, fall, byte_valid, rx_ferr, accept;

    assign rx_s = sync_q[1];
    assign fall = rx_prev_q & ~rx_s;

    // Byte receiver: byte_valid/rx_ferr are single-cycle strobes on the stop-bit sample.
    always_comb begin
        sync_d     = {sync_q[0], uart_rx};
        rx_prev_d  = rx_s;
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    bit_idx_d  = 3'd0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    byte_valid = rx_s;
                    rx_ferr    = ~rx_s;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Packet parser, inter-byte timeout and button hold timer.
    always_comb begin
        p_state_d     = p_state_q;
        sw_hi_d       = sw_hi_q;
        sw_lo_d       = sw_lo_q;
        btn_byte_d    = btn_byte_q;
        tmo_d         = '0;
        hold_d        = hold_q;
        sw_d          = sw_q;
        btn_d         = btn_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        accept        = 1'b0;
        if (rx_ferr) begin
            frame_err_d = 1'b1;
            p_state_d   = P_HDR;
        end else if (byte_valid) begin
            case (p_state_q)
                P_HDR: if (shift_q == 8'hA5) p_state_d = P_SWH;
                P_SWH: begin sw_hi_d = shift_q;    p_state_d = P_SWL; end
                P_SWL: begin sw_lo_d = shift_q;    p_state_d = P_BTN; end
                P_BTN: begin btn_byte_d = shift_q; p_state_d = P_CHK; end
                P_CHK: begin
                    p_state_d = P_HDR;
                    if (shift_q == (sw_hi_q ^ sw_lo_q ^ btn_byte_q)) begin
                        accept        = 1'b1;
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: p_state_d = P_HDR;
            endcase
        end else if (p_state_q != P_HDR) begin
            if (tmo_q == TMO_LAST) begin
                frame_err_d = 1'b1;
                p_state_d   = P_HDR;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (accept) begin
            sw_d   = {sw_hi_q, sw_lo_q};
            btn_d  = btn_byte_q[3:0];
            hold_d = HOLD_LOAD;
        end else if (BTN_HOLD_CYCLES > 0) begin
            if (hold_q != '0) hold_d = hold_q - HW'(1);
            else              btn_d  = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q        <= 2'b11;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            p_state_q     <= P_HDR;
            sw_hi_q       <= 8'h00;
            sw_lo_q       <= 8'h00;
            btn_byte_q    <= 8'h00;
            tmo_q         <= '0;
            hold_q        <= '0;
            sw_q          <= 16'h0000;
            btn_q         <= 4'h0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            rx_prev_q     <= rx_prev_d;
            rx_state_q    <= rx_state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            p_state_q     <= p_state_d;
            sw_hi_q       <= sw_hi_d;
            sw_lo_q       <= sw_lo_d;
            btn_byte_q    <= btn_byte_d;
            tmo_q         <= tmo_d;
            hold_q        <= hold_d;
            sw_q          <= sw_d;
            btn_q         <= btn_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign sw_out      = sw_q;
    assign btn_out     = btn_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_io_bridge.sv
// Randomized packet stimulus against a byte-queue reference of the packet rules,
// with exact stop-sample latency and button-hold timing.
module tb_uart_io_bridge;

    localparam int CPB  = 16;
    localparam int TMO  = 500;
    localparam int HOLD = 100;
    // start-bit drive to frame_valid: 2 sync flops + edge detect, half bit, 8 data bits, stop bit
    localparam int LAT  = 3 + CPB / 2 + 9 * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic [15:0] sw_out;
    logic [3:0]  btn_out;
    logic        frame_valid;
    logic        frame_err;

    uart_io_bridge #(
        .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO), .BTN_HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .sw_out(sw_out),
        .btn_out(btn_out), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int obs_fv = 0, obs_fe = 0, both = 0, last_fv_cyc = -1;
    int errors = 0, checks = 0;

    logic [7:0]  pkt[$];
    logic [15:0] m_sw = 16'h0;
    logic [3:0]  m_btn = 4'h0;
    bit          m_has = 1'b0;
    int          m_acc = 0;
    int          exp_fv = 0, exp_fe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin obs_fv++; last_fv_cyc = cyc; end
        if (frame_err) obs_fe++;
        if (frame_valid && frame_err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        logic [3:0] eb;
        eb = (m_has && (cyc - m_acc <= HOLD)) ? m_btn : 4'h0;
        chk({tag, ".sw"}, 32'(sw_out), 32'(m_sw));
        chk({tag, ".btn"}, 32'(btn_out), 32'(eb));
        chk({tag, ".nvalid"}, obs_fv, exp_fv);
        chk({tag, ".nerr"}, obs_fe, exp_fe);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok, input int c0);
        if (!ok) begin
            exp_fe++;
            pkt.delete();
        end else if (pkt.size() != 0 || b == 8'hA5) begin
            pkt.push_back(b);
            if (pkt.size() == 5) begin
                if ((pkt[1] ^ pkt[2] ^ pkt[3]) == pkt[4]) begin
                    exp_fv++;
                    m_sw  = {pkt[1], pkt[2]};
                    m_btn = pkt[3][3:0];
                    m_has = 1'b1;
                    m_acc = c0 + LAT;
                    chk("latency", last_fv_cyc, c0 + LAT);
                end else begin
                    exp_fe++;
                end
                pkt.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        int c0;
        @(negedge clk);
        uart_rx = 1'b0;
        c0 = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        model_byte(b, stop_ok, c0);
        check_state("byte");
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] l,
                              input logic [7:0] bt, input logic [7:0] ck);
        logic [7:0] fr [5];
        fr[0] = 8'hA5; fr[1] = h; fr[2] = l; fr[3] = bt; fr[4] = ck;
        for (int i = 0; i < 5; i++) begin
            send_byte(fr[i], 1'b1);
            idle($urandom_range(0, 40));
        end
    endtask

    task automatic model_reset();
        m_sw = 16'h0; m_btn = 4'h0; m_has = 1'b0;
        pkt.delete();
    endtask

    initial begin
        logic [7:0] h, l, bt, ck, jb;
        int kind;
        logic [7:0] resync [8];

        rst_n = 1'b0;
        uart_rx = 1'b1;
        idle(4);
        chk("rst.sw", 32'(sw_out), 32'h0);
        chk("rst.btn", 32'(btn_out), 32'h0);
        chk("rst.valid", 32'(frame_valid), 32'h0);
        chk("rst.err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        idle(1000);
        check_state("idle1000");

        // directed valid frame with exact hold boundary
        send_frame(8'h12, 8'h34, 8'h05, 8'h23);
        idle(m_acc + HOLD - cyc);
        check_state("hold.last");
        idle(1);
        check_state("hold.clear");
        chk("hold.sw", 32'(sw_out), 32'h1234);

        send_frame(8'h12, 8'h34, 8'h05, 8'h24);
        check_state("badchk");

        resync[0] = 8'h00; resync[1] = 8'hFF; resync[2] = 8'h5A; resync[3] = 8'hA5;
        resync[4] = 8'hAB; resync[5] = 8'hCD; resync[6] = 8'h0F; resync[7] = 8'h69;
        for (int i = 0; i < 8; i++) send_byte(resync[i], 1'b1);
        chk("resync.sw", 32'(sw_out), 32'hABCD);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b0);
        idle(20);
        send_frame(8'h00, 8'h01, 8'h02, 8'h03);
        chk("ferr.sw", 32'(sw_out), 32'h0001);

        // inter-byte timeout
        send_byte(8'hA5, 1'b1);
        send_byte(8'h77, 1'b1);
        idle(600);
        exp_fe++;
        pkt.delete();
        check_state("timeout");

        // reset in the middle of a byte of a partial frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        @(negedge clk);
        uart_rx = 1'b0;
        idle(3 * CPB);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        idle(4);
        model_reset();
        check_state("midrst");
        rst_n = 1'b1;
        idle(20);
        send_frame(8'h5C, 8'h3E, 8'h09, 8'h5C ^ 8'h3E ^ 8'h09);
        check_state("postrst");

        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 3);
            h  = 8'($urandom);
            l  = 8'($urandom);
            bt = 8'($urandom);
            if ($urandom_range(0, 3) == 0) h = 8'hA5;
            ck = h ^ l ^ bt;
            case (kind)
                0: send_frame(h, l, bt, ck);
                1: send_frame(h, l, bt, ck ^ (8'h01 << $urandom_range(0, 7)));
                2: begin
                    jb = 8'($urandom);
                    if (jb == 8'hA5) jb = 8'h5A;
                    send_byte(jb, 1'b1);
                end
                default: begin
                    send_byte(8'hA5, 1'b1);
                    send_byte(h, 1'b0);
                end
            endcase
            idle($urandom_range(0, 300));
            check_state("rand");
        end

        chk("exclusive", both, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
